sm_add_acc_pipe: RTL

- Parametrised, pipelined sign-magnitude adder/accumulator; next generation of the 4-bit ROM-based sign-magnitude adder.
- Operand width is parametrised and the sum is computed arithmetically, not by table lookup.
- Adds valid qualification, per-result overflow flag, sticky overflow, selectable saturate/zero-on-overflow, and a running-accumulator mode.
- Sits between switch/register inputs and display or downstream datapath logic.

---
 rtl/sm_add_acc_pipe_if.sv | 26 ++
 rtl/sm_add_acc_pipe.sv | 110 +++++++++++
 2 files changed

// File: rtl/sm_add_acc_pipe_if.sv
// Operand/result bundle for the sign-magnitude adder/accumulator.
// master drives operands and controls; slave (the datapath) returns results.
interface sm_add_acc_pipe_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         mode;
  logic         acc_clr;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         ovf;
  logic         ovf_sticky;
  logic [W-1:0] acc;

  modport master (
    output in_valid, a, b, mode, acc_clr,
    input  out_valid, sum, ovf, ovf_sticky, acc
  );

  modport slave (
    input  in_valid, a, b, mode, acc_clr,
    output out_valid, sum, ovf, ovf_sticky, acc
  );
endinterface

// File: rtl/sm_add_acc_pipe.sv
// Pipelined sign-magnitude adder/accumulator with overflow zero/saturate policy.
// Latency 2 cycles, 1 op/cycle, no backpressure: every valid input is accepted.
module sm_add_acc_pipe #(
  parameter int W   = 4,
  parameter bit SAT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  sm_add_acc_pipe_if.slave io
);
  localparam int MW = W - 1;

  logic          v1_q, v1_d;
  logic [W-1:0]  a1_q, a1_d;
  logic [W-1:0]  b1_q, b1_d;
  logic          mode1_q, mode1_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          ovf_q, ovf_d;
  logic          ovf_sticky_q, ovf_sticky_d;
  logic [W-1:0]  acc_q, acc_d;

  logic [W-1:0]  x;
  logic [MW-1:0] ma, mx, mag;
  logic [W-1:0]  mag_sum;
  logic          sa, sx, sgn, res_ovf;
  logic [W-1:0]  res;

  // Stage-2 arithmetic; reads acc_q directly so back-to-back accumulates see the latest value.
  always_comb begin
    x       = mode1_q ? acc_q : b1_q;
    sa      = a1_q[W-1];
    sx      = x[W-1];
    ma      = a1_q[MW-1:0];
    mx      = x[MW-1:0];
    mag_sum = {1'b0, ma} + {1'b0, mx};
    mag     = '0;
    sgn     = sa;
    res_ovf = 1'b0;
    res     = '0;
    if (sa == sx) begin
      mag     = mag_sum[MW-1:0];
      res_ovf = mag_sum[W-1];
    end else if (ma >= mx) begin
      mag = ma - mx;
    end else begin
      mag = mx - ma;
      sgn = sx;
    end
    // Zero magnitude always leaves as +0, which also absorbs -0 inputs.
    if (res_ovf) begin
      res = SAT ? {sgn, {MW{1'b1}}} : '0;
    end else if (mag != '0) begin
      res = {sgn, mag};
    end
  end

  always_comb begin
    v1_d         = io.in_valid;
    a1_d         = io.a;
    b1_d         = io.b;
    mode1_d      = io.mode;
    out_valid_d  = v1_q;
    sum_d        = sum_q;
    ovf_d        = ovf_q;
    acc_d        = acc_q;
    ovf_sticky_d = ovf_sticky_q;
    if (v1_q) begin
      sum_d = res;
      ovf_d = res_ovf;
      if (mode1_q) acc_d = res;
      if (res_ovf) ovf_sticky_d = 1'b1;
    end
    // Clear wins over a completing accumulate; the result itself is still reported.
    if (io.acc_clr) begin
      acc_d        = '0;
      ovf_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q         <= 1'b0;
      a1_q         <= '0;
      b1_q         <= '0;
      mode1_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      sum_q        <= '0;
      ovf_q        <= 1'b0;
      ovf_sticky_q <= 1'b0;
      acc_q        <= '0;
    end else begin
      v1_q         <= v1_d;
      a1_q         <= a1_d;
      b1_q         <= b1_d;
      mode1_q      <= mode1_d;
      out_valid_q  <= out_valid_d;
      sum_q        <= sum_d;
      ovf_q        <= ovf_d;
      ovf_sticky_q <= ovf_sticky_d;
      acc_q        <= acc_d;
    end
  end

  assign io.out_valid  = out_valid_q;
  assign io.sum        = sum_q;
  assign io.ovf        = ovf_q;
  assign io.ovf_sticky = ovf_sticky_q;
  assign io.acc        = acc_q;
endmodule
